// File: rtl/prod_accum_pkg.sv
// Shared types and constants for the block product accumulator.
package prod_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int ACC_W_DEF = 40;
    localparam int LEN_W_DEF = 8;
    localparam int PROD_W    = 32;

    // Bounds are built at 64 bits and truncated by the user to ACC_W.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/prod_accum_sat_add.sv
// Signed saturating adder: one extra guard bit detects overflow.
module sat_add
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [63:0] MAX_64 = sat_max(ACC_W);
    localparam logic [63:0] MIN_64 = sat_min(ACC_W);
    localparam logic [ACC_W-1:0] MAX_V = MAX_64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] MIN_V = MIN_64[ACC_W-1:0];

    logic [ACC_W:0] wide;

    assign wide = {acc[ACC_W-1], acc} + {addend[ACC_W-1], addend};

    always_comb begin
        ovf = wide[ACC_W] ^ wide[ACC_W-1];
        sum = wide[ACC_W-1:0];
        if (ovf) begin
            sum = wide[ACC_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/prod_accum.sv
// Sums len consecutive valid multiplier products into a saturating
// accumulator and offers the block result on a valid/ready port.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      product,
    input  logic             prod_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             out_ready,
    output logic             sat,
    output logic             busy
);

    state_t           state;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] sum;
    logic             ovf;

    assign ext = {{(ACC_W - PROD_W){product[31]}}, product};

    sat_add #(.ACC_W(ACC_W)) u_add (
        .acc    (acc_out),
        .addend (ext),
        .sum    (sum),
        .ovf    (ovf)
    );

    assign acc_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    // acc_out doubles as the running sum; it is only qualified in HOLD.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            count   <= '0;
            len_q   <= '0;
            acc_out <= '0;
            sat     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        count   <= '0;
                        acc_out <= '0;
                        sat     <= 1'b0;
                        state   <= (len == '0) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (prod_valid) begin
                        acc_out <= sum;
                        sat     <= sat | ovf;
                        count   <= count + 1'b1;
                        if (count == len_q - 1'b1) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: default width and ACC_W = 33 side by side.
module tb_prod_accum;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  len;
    logic [31:0] product;
    logic        prod_valid;
    logic        out_ready;

    logic [39:0] acc40;
    logic        av40, sat40, busy40;
    logic [32:0] acc33;
    logic        av33, sat33, busy33;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string             name;
        int                lenv;
        int                n;
        logic [0:7][31:0]  p;
        logic [0:7]        v;
        logic [39:0]       e40;
        logic              s40;
        logic [32:0]       e33;
        logic              s33;
    } vec_t;

    vec_t tv[7];

    always #5 clk = ~clk;

    prod_accum dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len),
        .product(product), .prod_valid(prod_valid),
        .acc_out(acc40), .acc_valid(av40), .out_ready(out_ready),
        .sat(sat40), .busy(busy40)
    );

    prod_accum #(.ACC_W(33)) dut33 (
        .clk(clk), .rstn(rstn), .start(start), .len(len),
        .product(product), .prod_valid(prod_valid),
        .acc_out(acc33), .acc_valid(av33), .out_ready(out_ready),
        .sat(sat33), .busy(busy33)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic begin_block(input string name, input int lenv);
        @(negedge clk);
        start = 1'b1;
        len = lenv[7:0];
        prod_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({name, " busy"}, 64'(busy40), 64'd1);
    endtask

    task automatic end_block(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " valid drop"}, 64'(av40), 64'd0);
        chk({name, " idle"}, 64'({busy40, busy33}), 64'd0);
    endtask

    initial begin
        tv[0] = '{"sum4", 4, 4, '{100, -32'sd30, 7, 1, 0, 0, 0, 0},
                  8'b1111_0000, 40'd78, 1'b0, 33'd78, 1'b0};
        tv[1] = '{"bubbles", 3, 5,
                  '{5, 32'h0BAD_0BAD, 32'h0BAD_0BAD, 6, 7, 0, 0, 0},
                  8'b1001_1000, 40'd18, 1'b0, 33'd18, 1'b0};
        tv[2] = '{"pos_sat", 3, 3,
                  '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0, 0, 0},
                  8'b1110_0000, 40'd6442450941, 1'b0, 33'h0_FFFF_FFFF, 1'b1};
        tv[3] = '{"neg_sat", 3, 3,
                  '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0},
                  8'b1110_0000, 40'hFE_8000_0000, 1'b0, 33'h1_0000_0000, 1'b1};
        tv[4] = '{"len0", 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0},
                  8'b0000_0000, 40'd0, 1'b0, 33'd0, 1'b0};
        tv[5] = '{"sticky", 4, 4,
                  '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                    0, 0, 0, 0},
                  8'b1111_0000, 40'h00_FFFF_FFFD, 1'b0, 33'h0_7FFF_FFFF, 1'b1};
        tv[6] = '{"neg_small", 2, 2, '{-32'sd5, 3, 0, 0, 0, 0, 0, 0},
                  8'b1100_0000, 40'hFF_FFFF_FFFE, 1'b0, 33'h1_FFFF_FFFE, 1'b0};

        rstn = 1'b0;
        start = 1'b0;
        len = '0;
        product = '0;
        prod_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset acc", 64'(acc40), 64'd0);
        chk("reset flags", 64'({av40, sat40, busy40, av33, sat33, busy33}),
            64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post reset busy", 64'(busy40), 64'd0);

        for (int i = 0; i < 7; i++) begin
            int early;
            early = 0;
            begin_block(tv[i].name, tv[i].lenv);
            for (int k = 0; k < tv[i].n; k++) begin
                if (av40) early++;
                product = tv[i].p[k];
                prod_valid = tv[i].v[k];
                @(negedge clk);
            end
            prod_valid = 1'b0;
            product = '0;
            chk({tv[i].name, " early valid"}, 64'(early), 64'd0);
            chk({tv[i].name, " valid"}, 64'({av40, av33}), 64'd3);
            chk({tv[i].name, " acc40"}, 64'(acc40), 64'(tv[i].e40));
            chk({tv[i].name, " sat40"}, 64'(sat40), 64'(tv[i].s40));
            chk({tv[i].name, " acc33"}, 64'(acc33), 64'(tv[i].e33));
            chk({tv[i].name, " sat33"}, 64'(sat33), 64'(tv[i].s33));
            end_block(tv[i].name);
        end

        // Result must sit still under back-pressure and ignore new work.
        begin_block("hold", 2);
        product = 32'd10; prod_valid = 1'b1;
        @(negedge clk);
        product = 32'd20;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            start = 1'b1; len = 8'd5;
            prod_valid = 1'b1; product = 32'd999;
            @(negedge clk);
            chk("hold acc", 64'(acc40), 64'd30);
            chk("hold valid", 64'(av40), 64'd1);
        end
        start = 1'b0; prod_valid = 1'b0; product = '0;
        end_block("hold");
        @(negedge clk);
        chk("hold no restart", 64'(busy40), 64'd0);

        // Max length: count must reach 254 without wrapping.
        begin
            int early;
            early = 0;
            begin_block("len255", 255);
            for (int k = 0; k < 255; k++) begin
                if (av40) early++;
                product = 32'd1; prod_valid = 1'b1;
                @(negedge clk);
            end
            prod_valid = 1'b0; product = '0;
            chk("len255 early valid", 64'(early), 64'd0);
            chk("len255 valid", 64'(av40), 64'd1);
            chk("len255 acc", 64'(acc40), 64'd255);
            end_block("len255");
        end

        // Reset mid-block abandons it.
        begin_block("midrst", 4);
        product = 32'd1000; prod_valid = 1'b1;
        @(negedge clk);
        product = 32'd2000;
        @(negedge clk);
        prod_valid = 1'b0; product = '0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst acc", 64'(acc40), 64'd0);
        chk("midrst flags", 64'({av40, sat40, busy40}), 64'd0);
        begin_block("after_rst", 1);
        product = -32'sd9; prod_valid = 1'b1;
        @(negedge clk);
        prod_valid = 1'b0; product = '0;
        chk("after_rst valid", 64'(av40), 64'd1);
        chk("after_rst acc", 64'(acc40), 64'(40'hFF_FFFF_FFF7));
        end_block("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
# prod_accum

Block-oriented accumulator placed directly downstream of the registered 16×16 two's-complement multiplier. It consumes the multiplier's 32-bit signed `product` one sample per cycle and sums `len` consecutive valid products into a wide saturating accumulator. It presents the block result with a valid/ready output handshake. Typical uses are dot products and FIR taps built on the existing multiplier.

## Interface
- `ACC_W`, default 40: accumulator/result width. Legal range is 33..64.
- `LEN_W`, default 8: width of the block-length field.

- `clk`, input, 1: single clock. All logic samples on the rising edge.
- `rstn`, input, 1: reset. Synchronous, active-low.
- `start`, input, 1: begin a block. Accepted only in IDLE.
- `len`, input, LEN_W: number of products in the block. Latched when `start` is accepted.
- `product`, input, 32: signed product, taken straight from the multiplier's output register.
- `prod_valid`, input, 1: `product` is valid this cycle. The upstream 2-cycle delay line aligns it with `product`.
- `acc_out`, output, ACC_W: signed block sum. Registered.
- `acc_valid`, output, 1: `acc_out` is valid.
- `out_ready`, input, 1: consumer accepts `acc_out`.
- `sat`, output, 1: sticky per block. Set if any addition in the current block saturated.
- `busy`, output, 1: high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: `start` = 1 latches `len`, clears the accumulator, count and `sat`.
    - `len` ≠ 0 → ACCUM.
    - `len` = 0 → HOLD with `acc_out` = 0.
  - ACCUM: each cycle with `prod_valid` = 1:
    - acc ← sat_add(acc, sign-extended `product`).
    - count ← count + 1.
    - When count = len − 1 and `prod_valid` = 1 → HOLD.
    - `prod_valid` = 0 is a bubble: no add, no count change.
  - HOLD: `acc_valid` = 1; `acc_out` and `sat` are stable. `acc_valid && out_ready` → IDLE.
- Arithmetic:
  - `product` is sign-extended to ACC_W and the sum is computed at ACC_W+1 bits.
  - Positive overflow clamps to 2^(ACC_W−1) − 1; negative overflow clamps to −2^(ACC_W−1). Either case sets `sat`.
- `start` outside IDLE is ignored. `prod_valid` in IDLE or HOLD is ignored; those products are dropped.
- No back-pressure toward the multiplier. The upstream source must not issue products while `busy` = 1 and state = HOLD.
- Reset values: state = IDLE, `acc_out` = 0, `acc_valid` = 0, `sat` = 0, `busy` = 0, internal count = 0, latched len = 0.
- Reset asserted mid-block abandons the block on the next edge with no output. A reset asserted in HOLD drops the pending result.

## Timing
- `start` at edge T (IDLE) → `busy` = 1 from T+1.
- The first product is accepted at T+1 or later.
- The last product accepted at edge E → `acc_valid` = 1 and the final `acc_out` visible from E+1.
- With no bubbles: block latency is len + 1 cycles from `start` to `acc_valid`.
- `len` = 0: `acc_valid` = 1 from T+1 with `acc_out` = 0.
- Handshake completes at the edge where `acc_valid && out_ready`. `acc_valid` = 0 and `busy` = 0 from the next cycle.
- Earliest next `start` acceptance is the cycle after the handshake, giving 1 idle cycle between blocks.
- `len` = 2^LEN_W − 1 is the maximum. The count must not wrap before the terminal compare.

## Structure
- Shared package `prod_accum_pkg`:
  - State enum {IDLE, ACCUM, HOLD}.
  - Default ACC_W / LEN_W constants.
  - Saturation bound constants derived from ACC_W.
- One combinational sub-module, `sat_add`:
  - Parameterised by ACC_W.
  - Inputs: acc, addend. Outputs: sum, ovf.
  - Instantiated once in the ACCUM datapath.
- The FSM, count and output registers live in `prod_accum`.

## Test plan
- Reset then `len` = 4, products 100, −30, 7, 1 back-to-back → `acc_out` = 78 and `sat` = 0. `acc_valid` rises 5 cycles after `start`.
- `len` = 3, products 5, bubble, bubble, 6, 7 → `acc_out` = 18. `acc_valid` is delayed by the 2 bubble cycles.
- ACC_W = 33, `len` = 3, products 0x7FFF_FFFF ×3 → `acc_out` = 2^32 − 1 and `sat` = 1. Repeat with 0x8000_0000 ×3 → `acc_out` = −2^32 and `sat` = 1.
- Hold `out_ready` = 0 for 10 cycles in HOLD while driving `start` and `prod_valid` → `acc_out` unchanged and no new block starts. Then `out_ready` = 1 → IDLE on the next cycle.
- `len` = 0 → `acc_valid` = 1 the cycle after `start`, with `acc_out` = 0.
- Assert `rstn` = 0 for one cycle after 2 of 4 products → all outputs read reset values. A new `len` = 1 block with product −9 yields `acc_out` = −9.
